// File: rtl/square_rr_scheduler_pkg.sv
// Shared constants and helpers for the squarer scheduler slice.
package square_rr_scheduler_pkg;

  // Default operand width of the shared squarer.
  localparam int unsigned OP_W_DEF = 128;

  // Pipeline latency of the shared squarer (sq_start to sq_done, in cycles).
  localparam int unsigned SQ_LAT = 3;

  // Result width of a square of an op_w-bit operand.
  function automatic int unsigned res_w(input int unsigned op_w);
    return 2 * op_w;
  endfunction

  // Smallest requester-id width with 2**id_w >= n_req.
  function automatic int unsigned id_w_min(input int unsigned n_req);
    return (n_req < 2) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/square_rr_scheduler_if.sv
// Client-side bundle: requests/operands in, grants and tagged results out.
interface square_rr_scheduler_if
  import square_rr_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = id_w_min(N_REQ),
  parameter int unsigned OP_W  = OP_W_DEF
);

  logic [N_REQ-1:0]      req;
  logic [N_REQ*OP_W-1:0] a_in;
  logic [N_REQ-1:0]      gnt;
  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [2*OP_W-1:0]     resp_square;

  // Requester side.
  modport master (
    output req, a_in,
    input  gnt, resp_valid, resp_id, resp_square
  );

  // Scheduler side.
  modport slave (
    input  req, a_in,
    output gnt, resp_valid, resp_id, resp_square
  );

endinterface

// File: rtl/square_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// set, searching cyclically from last_i+1. The pointer lives in the parent.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  input  logic [ID_W-1:0]  last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_id_o,
  output logic             any_o
);

  // Rotating priority search starting just after the last winner.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_i) + k) % N_REQ;
      if (en_i && !any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_id_o   = ID_W'(idx);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/square_rr_scheduler.sv
// Shares one fixed-latency pipelined squarer between N_REQ requesters.
// Round-robin accept, one per cycle, at most MAX_OUT in flight; an in-order
// tag FIFO returns each result with the id of the requester that issued it.
module square_rr_scheduler
  import square_rr_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = id_w_min(N_REQ),
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned OP_W    = OP_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  square_rr_scheduler_if.slave cli,
  output logic                sq_start,
  output logic [OP_W-1:0]     sq_a,
  input  logic [2*OP_W-1:0]   sq_square,
  input  logic                sq_done,
  output logic                busy,
  output logic                err
);

  localparam int unsigned RES_W = res_w(OP_W);
  localparam int unsigned PTR_W = (MAX_OUT < 2) ? 1 : $clog2(MAX_OUT);
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [ID_W-1:0]  last_q;
  logic [ID_W-1:0]  tag_q [MAX_OUT];
  logic [PTR_W-1:0] wr_q, rd_q;

  logic             sq_start_q;
  logic [OP_W-1:0]  sq_a_q;
  logic             resp_valid_q;
  logic [ID_W-1:0]  resp_id_q;
  logic [RES_W-1:0] resp_square_q;
  logic             err_q;

  logic             can_accept;
  logic             accept;
  logic             pop;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic [OP_W-1:0]  op_sel;

  // Outstanding count equals FIFO occupancy, so it doubles as the empty flag.
  assign can_accept = !rst && (count_q < CNT_W'(MAX_OUT));
  assign pop        = sq_done && (count_q != '0);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i    (cli.req),
    .en_i     (can_accept),
    .last_i   (last_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .any_o    (accept)
  );

  // Operand of the granted requester (grant is one-hot, so OR-reduce).
  always_comb begin
    op_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) op_sel = op_sel | cli.a_in[i*OP_W +: OP_W];
    end
  end

  // Next outstanding count: accept and pop in the same cycle cancel.
  always_comb begin
    count_d = count_q;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state, issue register, response register and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      last_q        <= ID_W'(N_REQ - 1);
      wr_q          <= '0;
      rd_q          <= '0;
      sq_start_q    <= 1'b0;
      sq_a_q        <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_square_q <= '0;
      err_q         <= 1'b0;
    end else begin
      count_q      <= count_d;
      sq_start_q   <= accept;
      resp_valid_q <= pop;
      if (accept) begin
        last_q <= gnt_id;
        sq_a_q <= op_sel;
        wr_q   <= wr_q + PTR_W'(1);
      end
      if (pop) begin
        resp_id_q     <= tag_q[rd_q];
        resp_square_q <= sq_square;
        rd_q          <= rd_q + PTR_W'(1);
      end
      if (sq_done && (count_q == '0)) err_q <= 1'b1;
    end
  end

  // Tag FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (accept) tag_q[wr_q] <= gnt_id;
  end

  assign cli.gnt         = gnt;
  assign cli.resp_valid  = resp_valid_q;
  assign cli.resp_id     = resp_id_q;
  assign cli.resp_square = resp_square_q;
  assign sq_start        = sq_start_q;
  assign sq_a            = sq_a_q;
  assign busy            = (count_q != '0);
  assign err             = err_q;

endmodule

// File: tb/tb_square_rr_scheduler.sv
// Directed bench for square_rr_scheduler with a scoreboard of expected
// (id, square) pairs pushed at grant and popped at resp_valid.
module tb_square_rr_scheduler;
  import square_rr_scheduler_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned MO = 4;
  localparam int unsigned OW = 128;
  localparam int unsigned RW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  square_rr_scheduler_if #(.N_REQ(N), .ID_W(IW), .OP_W(OW)) cif ();

  logic          sq_start, sq_done, busy, err;
  logic [OW-1:0] sq_a;
  logic [RW-1:0] sq_square;

  square_rr_scheduler #(
    .N_REQ   (N),
    .ID_W    (IW),
    .MAX_OUT (MO),
    .OP_W    (OW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cli       (cif),
    .sq_start  (sq_start),
    .sq_a      (sq_a),
    .sq_square (sq_square),
    .sq_done   (sq_done),
    .busy      (busy),
    .err       (err)
  );

  function automatic logic [RW-1:0] sqr(input logic [OW-1:0] a);
    logic [RW-1:0] w;
    w = {{OW{1'b0}}, a};
    return w * w;
  endfunction

  // Squarer model: SQ_LAT-stage pipeline, or a manual stub holding results.
  logic [SQ_LAT-1:0] pv;
  logic [RW-1:0]     pd [SQ_LAT];
  bit                stub    = 1'b0;
  logic              man_done = 1'b0;
  logic [RW-1:0]     man_sq  = '0;
  logic [OW-1:0]     hq [$];

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv[0] <= sq_start;
      pd[0] <= sqr(sq_a);
      for (int i = 1; i < SQ_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  always @(posedge clk) begin
    if (rst) hq.delete();
    else if (stub && sq_start) hq.push_back(sq_a);
  end

  assign sq_done   = stub ? man_done : pv[SQ_LAT-1];
  assign sq_square = stub ? man_sq   : pd[SQ_LAT-1];

  typedef struct {
    logic [IW-1:0] id;
    logic [RW-1:0] sq;
  } exp_t;

  exp_t          sb [$];
  int            gnt_log [$];
  int            rid_log [$];
  logic [RW-1:0] rsq_log [$];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: record grants into the scoreboard, check every response.
  logic [N-1:0] mg;
  exp_t         me;
  always @(negedge clk) begin
    if (!rst) begin
      mg = cif.gnt;
      if (mg != '0) begin
        chk("gnt_onehot", RW'($onehot(mg)), 1);
        for (int i = 0; i < N; i++) begin
          if (mg[i]) begin
            gnt_log.push_back(i);
            sb.push_back('{id: IW'(i), sq: sqr(cif.a_in[i*OW +: OW])});
          end
        end
      end
      if (cif.resp_valid) begin
        rid_log.push_back(int'(cif.resp_id));
        rsq_log.push_back(cif.resp_square);
        chk("resp_has_expected", RW'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          me = sb.pop_front();
          chk("resp_id", RW'(cif.resp_id), RW'(me.id));
          chk("resp_square", cif.resp_square, me.sq);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_a(input int i, input logic [OW-1:0] v);
    cif.a_in[i*OW +: OW] = v;
  endtask

  task automatic clear_logs();
    sb.delete();
    gnt_log.delete();
    rid_log.delete();
    rsq_log.delete();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    clear_logs();
    tick();
    rst = 1'b0;
  endtask

  // Raise mask bits, drop each requester the cycle after its grant.
  task automatic run_reqs(input logic [N-1:0] mask, input int n);
    int got;
    logic [N-1:0] g;
    got = 0;
    cif.req = cif.req | mask;
    for (int c = 0; c < 60 && got < n; c++) begin
      neg();
      g = cif.gnt;
      tick();
      if (g != '0) begin
        got++;
        cif.req = cif.req & ~g;
      end
    end
    chk("run_reqs_grants", RW'(got), RW'(n));
  endtask

  task automatic drain();
    for (int c = 0; c < 60; c++) begin
      neg();
      if (!busy && !cif.resp_valid && sb.size() == 0) break;
      tick();
    end
    chk("drain_busy", RW'(busy), 0);
    chk("drain_sb_empty", RW'(sb.size()), 0);
    tick();
  endtask

  // Stub squarer: hand back the oldest held operand's square this cycle.
  task automatic rel();
    chk("stub_has_op", RW'(hq.size() != 0), 1);
    if (hq.size() != 0) man_sq = sqr(hq.pop_front());
    man_done = 1'b1;
  endtask

  int            ng;
  int            seen;
  logic [OW-1:0] big;
  int            exp_ids [6] = '{0, 1, 2, 3, 0, 3};
  int            exp_sqs [6] = '{100, 121, 144, 169, 100, 169};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cif.req  = '1;
    cif.a_in = '0;
    rst      = 1'b1;
    tick();
    tick();

    // Reset state, with requests asserted during reset.
    neg();
    chk("rst_gnt", RW'(cif.gnt), 0);
    chk("rst_sq_start", RW'(sq_start), 0);
    chk("rst_sq_a", RW'(sq_a), 0);
    chk("rst_resp_valid", RW'(cif.resp_valid), 0);
    chk("rst_resp_id", RW'(cif.resp_id), 0);
    chk("rst_resp_square", cif.resp_square, 0);
    chk("rst_busy", RW'(busy), 0);
    chk("rst_err", RW'(err), 0);
    tick();
    cif.req = '0;
    rst     = 1'b0;
    tick();

    // Single request: latency and value.
    set_a(2, 3);
    cif.req = 4'b0100;
    neg();
    chk("single_gnt", RW'(cif.gnt), 4'b0100);
    tick();
    cif.req = '0;
    neg();
    chk("single_sq_start", RW'(sq_start), 1);
    chk("single_sq_a", RW'(sq_a), 3);
    tick();
    neg();
    chk("single_sq_start_pulse", RW'(sq_start), 0);
    tick();
    tick();
    neg();
    chk("single_resp_early", RW'(cif.resp_valid), 0);
    tick();
    neg();
    chk("single_resp_valid", RW'(cif.resp_valid), 1);
    chk("single_resp_id", RW'(cif.resp_id), 2);
    chk("single_resp_square", cif.resp_square, 9);
    tick();
    drain();

    // Round robin from a fresh pointer.
    pulse_rst();
    for (int i = 0; i < N; i++) set_a(i, OW'(i + 10));
    run_reqs(4'b1111, 4);
    drain();
    run_reqs(4'b1001, 2);
    drain();
    chk("rr_gnt_count", RW'(gnt_log.size()), 6);
    chk("rr_resp_count", RW'(rid_log.size()), 6);
    for (int k = 0; k < 6; k++) begin
      chk("rr_gnt_order", RW'((k < gnt_log.size()) ? gnt_log[k] : -1), RW'(exp_ids[k]));
      chk("rr_resp_id_order", RW'((k < rid_log.size()) ? rid_log[k] : -1), RW'(exp_ids[k]));
      chk("rr_resp_square", (k < rsq_log.size()) ? rsq_log[k] : '1, RW'(exp_sqs[k]));
    end

    // Throttle at MAX_OUT with results withheld.
    pulse_rst();
    stub = 1'b1;
    for (int i = 0; i < N; i++) set_a(i, OW'(i + 20));
    cif.req = 4'b1111;
    ng = 0;
    for (int c = 0; c < 8; c++) begin
      neg();
      if (cif.gnt != '0) ng++;
      tick();
    end
    chk("thr_grant_count", RW'(ng), RW'(MO));
    neg();
    chk("thr_gnt_blocked", RW'(cif.gnt), 0);
    chk("thr_busy", RW'(busy), 1);
    tick();
    rel();
    neg();
    chk("thr_gnt_at_full_done", RW'(cif.gnt), 0);
    tick();
    man_done = 1'b0;
    neg();
    chk("thr_regrant", RW'(cif.gnt), 4'b0001);
    tick();
    ng = 0;
    for (int c = 0; c < 4; c++) begin
      neg();
      if (cif.gnt != '0) ng++;
      tick();
    end
    chk("thr_single_regrant", RW'(ng), 0);

    // Simultaneous accept and done at MAX_OUT-1 keeps the count.
    rel();
    neg();
    chk("sim_gnt_full", RW'(cif.gnt), 0);
    tick();
    rel();
    neg();
    chk("sim_gnt_with_done", RW'(cif.gnt), 4'b0010);
    tick();
    man_done = 1'b0;
    neg();
    chk("sim_count_unchanged", RW'(cif.gnt), 4'b0100);
    tick();
    neg();
    chk("sim_full_again", RW'(cif.gnt), 0);
    chk("sim_busy", RW'(busy), 1);
    tick();
    cif.req = '0;
    tick();
    tick();
    tick();
    for (int c = 0; c < 12; c++) begin
      if (hq.size() == 0) break;
      rel();
      tick();
    end
    man_done = 1'b0;
    drain();
    stub = 1'b0;

    // Reset with operations in flight.
    pulse_rst();
    for (int i = 0; i < N; i++) set_a(i, OW'(i + 1));
    run_reqs(4'b0111, 3);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      neg();
      if (cif.resp_valid) seen++;
      tick();
    end
    chk("rst_mid_no_resp", RW'(seen), 0);
    neg();
    chk("rst_mid_busy", RW'(busy), 0);
    tick();
    big = 128'h123456789ABCDEF0123456789ABCDEF0;
    set_a(0, big);
    for (int i = 1; i < N; i++) set_a(i, OW'(5));
    cif.req = 4'b1111;
    neg();
    chk("rst_mid_first_gnt", RW'(cif.gnt), 4'b0001);
    tick();
    cif.req = '0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      neg();
      if (cif.resp_valid) begin
        seen = 1;
        chk("big_resp_id", RW'(cif.resp_id), 0);
        chk("big_resp_square", cif.resp_square, sqr(big));
        break;
      end
      tick();
    end
    chk("big_resp_seen", RW'(seen), 1);
    tick();
    drain();

    // Spurious done with nothing outstanding.
    stub     = 1'b1;
    man_sq   = '1;
    man_done = 1'b1;
    neg();
    chk("err_before", RW'(err), 0);
    tick();
    man_done = 1'b0;
    neg();
    chk("err_set", RW'(err), 1);
    chk("err_no_resp", RW'(cif.resp_valid), 0);
    tick();
    tick();
    tick();
    neg();
    chk("err_sticky", RW'(err), 1);
    chk("err_busy", RW'(busy), 0);
    tick();
    pulse_rst();
    neg();
    chk("err_cleared", RW'(err), 0);
    tick();
    stub = 1'b0;

    chk("final_sb_empty", RW'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/square_rr_scheduler.md
Name: square_rr_scheduler

Overview:
- Shares one pipelined 128-bit squarer (start/done, fixed latency, no backpressure) between N requesters.
- Round-robin arbitration, one issue per cycle, bounded outstanding count, in-order tag FIFO so each result returns with its requester id.
- Sits between the squaring clients of the FPGA project (e.g. modexp sequencers) and the single squarer instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester id; must satisfy 2**ID_W >= N_REQ
- MAX_OUT, 4, max operations in flight (accepted, not yet sq_done); tag FIFO depth; power of 2
- OP_W, 128, operand width; result width is 2*OP_W

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester request; held high until granted
- a_in  in  N_REQ*OP_W  operands; requester i uses bits [i*OP_W +: OP_W]
- gnt  out  N_REQ  one-hot accept, combinational, same cycle as acceptance
- resp_valid  out  1  one-cycle pulse: result available
- resp_id  out  ID_W  requester index of the result
- resp_square  out  2*OP_W  squared value
- sq_start  out  1  issue pulse to squarer
- sq_a  out  OP_W  operand to squarer
- sq_square  in  2*OP_W  squarer result
- sq_done  in  1  squarer result-valid pulse
- busy  out  1  count != 0
- err  out  1  sticky: sq_done received with tag FIFO empty

Behaviour:
- Clock/reset: one clock `clk`; `rst` synchronous, active-high.
- Reset: gnt, sq_start, resp_valid, busy, err = 0; sq_a, resp_square, resp_id = 0; count = 0; FIFO empty; rr pointer last = N_REQ-1, so requester 0 has highest priority first.
- Mid-operation reset: in-flight tags dropped, no responses. The squarer shares rst, so its results are also discarded.
- Acceptance, cycle t: if count < MAX_OUT and any req, grant the first requester with req set, searching from last+1 cyclically.
  - gnt[i] = 1 for that cycle only.
  - At the edge: operand latched, id pushed to FIFO, last <= i.
  - Requester may drop or change req and a_in from t+1.
- count = MAX_OUT: gnt = 0, nothing accepted, req ignored.
- Issue: sq_start = 1 and sq_a = latched operand in cycle t+1; both registered. sq_start is a single-cycle pulse per accept; back-to-back accepts give continuous sq_start.
- Count update, per edge: +1 on accept, -1 on sq_done with FIFO non-empty. Simultaneous accept and done leave count unchanged. The accept check uses the pre-edge count.
- Response: on sq_done with FIFO non-empty, in cycle+1:
  - resp_valid = 1
  - resp_square = sq_square (registered)
  - resp_id = popped FIFO head
  - No backpressure; consumers must take it.
- Latency: with squarer latency 3, gnt in cycle t gives sq_done in t+4 and resp_valid in t+5.
- Error: sq_done with FIFO empty sets err; the cycle produces no response and count does not change. err clears only on rst.
- FIFO: circular, MAX_OUT entries, wr/rd pointers wrap modulo MAX_OUT. Push and pop in the same cycle are legal, including at full.
- Ordering: results return in issue order; the squarer is in-order.

Decomposition:
- Shared package: OP_W default, result width 2*OP_W, squarer latency constant SQ_LAT = 3 (bench uses it), ID_W rule.
- Sub-module `rr_arbiter` (N_REQ, combinational one-hot grant from req, enable, last pointer). Pointer register stays in the parent.
- Tag FIFO stays inline.

Test Plan:
- Single request: req[2]=1, a=3 -> gnt[2] at t, sq_start at t+1, resp_valid at t+5 with resp_id=2 and resp_square=9.
- Round robin: req=4'b1111 held for 4 accepts -> grant order 0,1,2,3; then reassert req[0], req[3] -> order 0,3. With a_i = i+10, responses are 100, 121, 144, 169 in that id order.
- Throttle: MAX_OUT=4, all req held, sq_done withheld by a stub squarer -> exactly 4 gnts, then gnt=0 and busy=1. One sq_done -> exactly one more gnt the next cycle.
- Simultaneous accept + done at count=MAX_OUT-1 -> count unchanged, grant still issued, FIFO order preserved.
- Reset mid-flight: 3 accepted, rst pulsed at t+2 -> no resp_valid afterward, busy=0. The next request after reset is served by requester 0 first and squares 0x123456789ABCDEF0123456789ABCDEF0 correctly.
- Spurious sq_done with count=0 -> err=1 and stays high, no resp_valid. rst clears err.
